bf16_mul_post_pipe: RTL and testbench

- Downstream stage of the approximate BF16 multiplier datapath.
- Consumes the carry-save mantissa product (mults/multc), the provisional exponent, the product sign and operand class flags.
- Produces the final packed BF16 product.
- Two-stage valid/ready pipeline:
  - S1: carry-propagate add.
  - S2: normalise, round, handle exceptions, pack.
- Throughput 1 result/cycle; latency 2 cycles.

---
 rtl/bf16_mul_post_pipe.sv | 181 ++++++++++++++++++
 tb/tb_bf16_mul_post_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_mul_post_pipe.sv
// ---------------------------------------------------------------------------
// bf16_mul_post_pipe
//   Back end of the approximate BF16 multiplier. It takes the carry-save
//   mantissa product, the provisional exponent, the sign and the operand class
//   flags, and returns the packed BF16 product.
//   There are two valid/ready stages:
//     S1 : carry-propagate add of mults + multc
//     S2 : normalise, round, handle exceptions, pack
//   Throughput is one result per cycle. Latency is 2 cycles.
//
//   Optional feature macro: RNE_EN
//     defined   -> round-to-nearest-even in S2
//     undefined -> truncation; no guard/sticky logic is built
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake
//   mults, multc      carry-save mantissa product (MS_W bits)
//   expt              signed provisional exponent, expa+expb-127 (EXP_W bits)
//   spd               product sign
//   in_cls            {is_nan, is_inf, is_zero}, OR-combined over both operands
//   out_valid/out_ready downstream handshake
//   product           packed BF16 result
//   ovf, unf          result overflowed to inf / flushed to zero
// ---------------------------------------------------------------------------
module bf16_mul_post_pipe #(
    parameter int EXP_W = 10,
    parameter int MS_W  = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MS_W-1:0]  mults,
    input  logic [MS_W-1:0]  multc,
    input  logic [EXP_W-1:0] expt,
    input  logic             spd,
    input  logic [2:0]       in_cls,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      product,
    output logic             ovf,
    output logic             unf
);

    localparam int STAGES = 2;
    localparam logic signed [EXP_W:0] E_MAX  = (EXP_W+1)'(255);
    localparam logic signed [EXP_W:0] E_ZERO = '0;
    localparam logic signed [EXP_W:0] E_ONE  = (EXP_W+1)'(1);

    typedef struct packed {
        logic [15:0]      p;
        logic [EXP_W-1:0] expt;
        logic             spd;
        logic [2:0]       cls;   // {nan, inf, zero}
    } s1_t;

    s1_t               s1_q;
    logic [STAGES:1]   vld_pipe;   // [1]=S1 valid, [2]=S2 valid
    logic              s2_adv;
    logic              s1_adv;
    logic [MS_W-1:0]   psum;

    // S2 drains when empty or the consumer takes it. S1 moves when it is
    // empty or S2 frees up. in_ready depends on out_ready, not on in_valid.
    assign s2_adv    = !vld_pipe[2] | out_ready;
    assign s1_adv    = !vld_pipe[1] | s2_adv;
    assign in_ready  = !rst & s1_adv;
    assign out_valid = vld_pipe[2];

    // The sum is taken mod 2^MS_W. Only the low 16 bits are meaningful.
    assign psum = mults + multc;

    // ---------------- S2 combinational datapath ----------------
    logic signed [EXP_W:0] e_ext;
    logic signed [EXP_W:0] e_n;
    logic signed [EXP_W:0] e_r;
    logic [6:0]            frac_n;
    logic [6:0]            frac_r;
    logic [15:0]           prod_n;
    logic                  ovf_n;
    logic                  unf_n;
`ifdef RNE_EN
    logic                  guard;
    logic                  sticky;
    logic [7:0]            frac_inc;
`endif

    always_comb begin
        e_ext  = {s1_q.expt[EXP_W-1], s1_q.expt};
        e_n    = e_ext;
        frac_n = s1_q.p[13:7];
`ifdef RNE_EN
        guard  = s1_q.p[6];
        sticky = |s1_q.p[5:0];
`endif
        if (s1_q.p[15]) begin
            frac_n = s1_q.p[14:8];
            e_n    = e_ext + E_ONE;
`ifdef RNE_EN
            guard  = s1_q.p[7];
            sticky = |s1_q.p[6:0];
`endif
        end else if (!s1_q.p[14]) begin
            // Leading one fell to bit 13: a corner of the approximate mantissa
            frac_n = s1_q.p[12:6];
            e_n    = e_ext - E_ONE;
`ifdef RNE_EN
            guard  = s1_q.p[5];
            sticky = |s1_q.p[4:0];
`endif
        end

`ifdef RNE_EN
        frac_inc = {1'b0, frac_n} + {7'd0, guard & (sticky | frac_n[0])};
        frac_r   = frac_inc[6:0];
        // When the fraction wraps 7F->00, the implicit one moves up one place
        e_r      = e_n + {{EXP_W{1'b0}}, frac_inc[7]};
`else
        frac_r = frac_n;
        e_r    = e_n;
`endif

        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        if (s1_q.cls[2] | (s1_q.cls[1] & s1_q.cls[0])) begin
            prod_n = 16'h7FC0;                        // canonical qNaN
        end else if (s1_q.cls[1]) begin
            prod_n = {s1_q.spd, 8'hFF, 7'h0};
        end else if (s1_q.cls[0]) begin
            prod_n = {s1_q.spd, 15'h0};
        end else if (e_r >= E_MAX) begin
            prod_n = {s1_q.spd, 8'hFF, 7'h0};
            ovf_n  = 1'b1;
        end else if (e_r <= E_ZERO) begin
            prod_n = {s1_q.spd, 15'h0};               // no subnormals
            unf_n  = 1'b1;
        end else begin
            prod_n = {s1_q.spd, e_r[7:0], frac_r};
        end
    end

    // Some bits are dropped on purpose: the carry-out of the add, and in the
    // truncating build the low product bits and the upper exponent bits.
    logic unused_bits;
    assign unused_bits = ^{psum[MS_W-1:16], e_r[EXP_W:8]
`ifndef RNE_EN
                           , s1_q.p[5:0]
`endif
                          };

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            product  <= 16'h0000;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_q.p    <= psum[15:0];
                    s1_q.expt <= expt;
                    s1_q.spd  <= spd;
                    s1_q.cls  <= in_cls;
                end
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    product <= prod_n;
                    ovf     <= ovf_n;
                    unf     <= unf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_bf16_mul_post_pipe.sv
module tb_bf16_mul_post_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] mults;
    logic [16:0] multc;
    logic [9:0]  expt;
    logic        spd;
    logic [2:0]  in_cls;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        ovf;
    logic        unf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] p;
        logic        o;
        logic        u;
    } res_t;
    res_t got_q[$];

    bf16_mul_post_pipe #(.EXP_W(10), .MS_W(17)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mults(mults), .multc(multc), .expt(expt), .spd(spd), .in_cls(in_cls),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // An output transfer happens on the posedge after this negedge sample.
    // Inputs only change at posedge+1, so they are stable in between.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            got_q.push_back('{p: product, o: ovf, u: unf});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set and returns at posedge+1 after the accept edge.
    task automatic send(input logic [16:0] ms, input logic [16:0] mc,
                        input logic [9:0] ex, input logic s, input logic [2:0] cls);
        int n;
        in_valid = 1'b1;
        mults = ms; multc = mc; expt = ex; spd = s; in_cls = cls;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $error("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [16:0] ms, input logic [16:0] mc,
                           input logic [9:0] ex, input logic s, input logic [2:0] cls,
                           input logic [15:0] ep, input logic eo, input logic eu);
        res_t r;
        got_q.delete();
        send(ms, mc, ex, s, cls);
        for (int i = 0; i < 10; i++) begin
            if (got_q.size() > 0) break;
            @(posedge clk);
        end
        #1;
        if (got_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout: no result observed, expected one", tag);
        end else begin
            r = got_q.pop_front();
            chk({tag, "_product"}, 32'(r.p), 32'(ep));
            chk({tag, "_ovf"}, 32'(r.o), 32'(eo));
            chk({tag, "_unf"}, 32'(r.u), 32'(eu));
        end
    endtask

    logic [15:0] exp_bp [4];
    logic [15:0] exp_tie, exp_rnd, exp_wrap;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mults = '0; multc = '0; expt = '0; spd = 1'b0; in_cls = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_product", 32'(product), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // 1.0 x 1.0 with the latency checked cycle by cycle
        send(17'h04000, 17'h0, 10'd127, 1'b0, 3'b000);
        chk("lat_out_valid_c1", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_out_valid_c2", 32'(out_valid), 1);
        chk("one_product", 32'(product), 32'h3F80);
        chk("one_ovf", 32'(ovf), 0);
        chk("one_unf", 32'(unf), 0);
        @(posedge clk);
        #1;
        got_q.delete();

        run_vec("onehalf",   17'h09000, 17'h00000, 10'd127, 1'b0, 3'b000, 16'h4010, 0, 0);
        run_vec("cs_split",  17'h08000, 17'h01000, 10'd127, 1'b0, 3'b000, 16'h4010, 0, 0);
        run_vec("cs_wrap",   17'h1FFFF, 17'h04001, 10'd127, 1'b0, 3'b000, 16'h3F80, 0, 0);
        run_vec("ovf",       17'h09000, 17'h00000, 10'd254, 1'b0, 3'b000, 16'h7F80, 1, 0);
        run_vec("e254",      17'h04000, 17'h00000, 10'd254, 1'b0, 3'b000, 16'h7F00, 0, 0);
        run_vec("unf",       17'h04000, 17'h00000, 10'd0,   1'b1, 3'b000, 16'h8000, 0, 1);
        run_vec("e1",        17'h04000, 17'h00000, 10'd1,   1'b0, 3'b000, 16'h0080, 0, 0);
        run_vec("neg_exp",   17'h04000, 17'h00000, 10'h3FB, 1'b0, 3'b000, 16'h0000, 0, 1);
        run_vec("low_norm",  17'h02000, 17'h00000, 10'd127, 1'b0, 3'b000, 16'h3F00, 0, 0);
        run_vec("nan",       17'h04000, 17'h00000, 10'd127, 1'b0, 3'b110, 16'h7FC0, 0, 0);
        run_vec("inf_zero",  17'h04000, 17'h00000, 10'd127, 1'b1, 3'b011, 16'h7FC0, 0, 0);
        run_vec("inf",       17'h04000, 17'h00000, 10'd0,   1'b1, 3'b010, 16'hFF80, 0, 0);
        run_vec("zero",      17'h09000, 17'h00000, 10'd254, 1'b1, 3'b001, 16'h8000, 0, 0);

`ifdef RNE_EN
        exp_tie = 16'h3F82; exp_rnd = 16'h3F82; exp_wrap = 16'h4000;
`else
        exp_tie = 16'h3F81; exp_rnd = 16'h3F81; exp_wrap = 16'h3FFF;
`endif
        run_vec("rnd_tie_odd",  17'h040C0, 17'h0, 10'd127, 1'b0, 3'b000, exp_tie, 0, 0);
        run_vec("rnd_above",    17'h040FF, 17'h0, 10'd127, 1'b0, 3'b000, exp_rnd, 0, 0);
        run_vec("rnd_wrap",     17'h07FC0, 17'h0, 10'd127, 1'b0, 3'b000, exp_wrap, 0, 0);
        run_vec("rnd_tie_even", 17'h04040, 17'h0, 10'd127, 1'b0, 3'b000, 16'h3F80, 0, 0);

        // Backpressure: four back-to-back inputs while the consumer stalls
        exp_bp[0] = 16'h3F80; exp_bp[1] = 16'h4010; exp_bp[2] = 16'h4100; exp_bp[3] = 16'hC010;
        got_q.delete();
        out_ready = 1'b0;
        fork
            begin
                send(17'h04000, 17'h0, 10'd127, 1'b0, 3'b000);
                send(17'h09000, 17'h0, 10'd127, 1'b0, 3'b000);
                send(17'h04000, 17'h0, 10'd130, 1'b0, 3'b000);
                send(17'h09000, 17'h0, 10'd127, 1'b1, 3'b000);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 32'(in_ready), 0);
                    chk("bp_out_valid", 32'(out_valid), 1);
                    chk("bp_product_held", 32'(product), 32'h3F80);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 30; i++) begin
            if (got_q.size() >= 4) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", 32'(got_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > 0) begin
                res_t r;
                r = got_q.pop_front();
                chk($sformatf("bp_order_%0d", i), 32'(r.p), 32'(exp_bp[i]));
            end
        end

        // Reset with both stages full
        out_ready = 1'b0;
        send(17'h04000, 17'h0, 10'd127, 1'b0, 3'b000);
        send(17'h09000, 17'h0, 10'd127, 1'b0, 3'b000);
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_in_ready", 32'(in_ready), 0);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_product", 32'(product), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", 32'(in_ready), 1);
        got_q.delete();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_stale", 32'(got_q.size()), 0);
        chk("midrst_out_valid_idle", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
